// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - operand/result handshake bundle for the serial adder
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  sum, cout, busy, done
  );

  modport slave (
    input  start, a, b,
    output sum, cout, busy, done
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder, LSB first, one bit per RUN cycle
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic ha1_s, ha1_c, ha2_s, ha2_c, bit_s, bit_c;
  logic [WIDTH-1:0] res_nxt;

  // one full-adder slice from two half adders
  assign ha1_s = a_sh[0] ^ b_sh[0];
  assign ha1_c = a_sh[0] & b_sh[0];
  assign ha2_s = ha1_s ^ carry;
  assign ha2_c = ha1_s & carry;
  assign bit_s = ha2_s;
  assign bit_c = ha1_c | ha2_c;

  // new bit enters at the MSB; the oldest bit falls out of the shift register
  assign res_nxt = {bit_s, res_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res_sh <= res_nxt[WIDTH-1:1];
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= bit_c;
          if (cnt == CW'(WIDTH - 1)) begin
            sum_q  <= res_nxt;
            cout_q <= bit_c;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();
  serial_add_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // issue one add from IDLE; scramble operands during RUN; check latency, busy span, held sum
  task automatic do_add(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] es, input logic ec);
    int lat, nbusy, nchg;
    logic [7:0] prev;
    prev = bus.sum;
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    lat = 1;
    nbusy = 0;
    nchg = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) nbusy++;
      if (bus.sum !== prev) nchg++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd9);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    chk({tag, "_sum_held"}, 32'(nchg), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int lat, ndone;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_add("zero", 8'h00, 8'h00, 8'h00, 1'b0);
    do_add("ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    do_add("a5_5a", 8'hA5, 8'h5A, 8'hFF, 1'b0);
    do_add("ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);

    // start held high during RUN with different operands must be ignored
    bus.start = 1'b1;
    bus.a = 8'h0F;
    bus.b = 8'h01;
    @(negedge clk);
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (lat >= 7) bus.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("ign_latency", 32'(lat), 32'd9);
    chk("ign_sum", 32'(bus.sum), 32'h10);
    chk("ign_cout", 32'(bus.cout), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("ign_single_done", 32'(ndone), 32'd0);

    // back-to-back with start held continuously
    bus.start = 1'b1;
    bus.a = 8'h80;
    bus.b = 8'h80;
    for (int l = 1; l <= 27; l++) begin
      @(negedge clk);
      chk("b2b_done", 32'(bus.done), 32'(l % 9 == 0));
      chk("b2b_busy", 32'(bus.busy), 32'(l % 9 != 0));
      if (l % 9 == 0) begin
        chk("b2b_sum", 32'(bus.sum), 32'h00);
        chk("b2b_cout", 32'(bus.cout), 32'd1);
      end
      if (l == 26) bus.start = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle_busy", 32'(bus.busy), 32'd0);
    chk("b2b_idle_done", 32'(bus.done), 32'd0);

    // reset in the 4th RUN cycle aborts the add
    do_add("pre_abort", 8'h03, 8'h04, 8'h07, 1'b0);
    bus.start = 1'b1;
    bus.a = 8'h11;
    bus.b = 8'h22;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_sum", 32'(bus.sum), 32'd0);
    chk("abort_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // first start after reset, then sum holds 0x07 through the next RUN
    do_add("post_rst", 8'h03, 8'h04, 8'h07, 1'b0);
    do_add("hold_sum", 8'h10, 8'h20, 8'h30, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
